pipe_ctrl: RTL and testbench

Central pipeline controller for the five-stage core. It turns per-stage stall requests and the MEM-stage exception report into the `stall_o` vector and `flush_o` pulse that drive every inter-stage register (PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB). It also supplies the redirect PC. A small FSM defers an exception that arrives while MEM is stalled, and guarantees one clean drain cycle after every flush.

---
 rtl/pipe_ctrl_if.sv | 25 ++
 rtl/pipe_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: per-stage stall requests and the MEM exception
// report flow into the controller; stall/flush/redirect flow back out.
interface pipe_ctrl_if;
  logic        stallreq_id_i;
  logic        stallreq_exe_i;
  logic        stallreq_mem_i;
  logic [31:0] exc_type_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [15:0] flush_cnt_o;

  // Pipeline side: raises requests, consumes stall/flush/redirect.
  modport master (
    output stallreq_id_i, stallreq_exe_i, stallreq_mem_i, exc_type_i, cp0_epc_i,
    input  stall_o, flush_o, new_pc_o, flush_cnt_o
  );

  // Controller side.
  modport slave (
    input  stallreq_id_i, stallreq_exe_i, stallreq_mem_i, exc_type_i, cp0_epc_i,
    output stall_o, flush_o, new_pc_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall vector, flush pulse and redirect PC.
// An exception seen while MEM is stalled is parked (DEFER) until MEM frees
// up; every flush is followed by one DRAIN cycle in which exceptions are
// ignored because the reporting instruction has just been cleared.
// There is no valid/ready handshake here: all requests are level signals
// sampled every cycle, and stall/flush/new_pc respond in the same cycle.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] ERET_CODE  = 32'h0000000E
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DEFER = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pend_type_q, pend_type_d;
  logic [31:0] pend_epc_q, pend_epc_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic [5:0]  base_stall;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;

  // Priority-encoded stall request: a later stage holds itself and everything before it.
  always_comb begin
    base_stall = 6'b000000;
    if (bus.stallreq_mem_i)      base_stall = 6'b011111;
    else if (bus.stallreq_exe_i) base_stall = 6'b001111;
    else if (bus.stallreq_id_i)  base_stall = 6'b000111;
  end

  // Next-state and output logic; a flush always forces the stall vector to zero.
  always_comb begin
    state_d     = state_q;
    pend_type_d = pend_type_q;
    pend_epc_d  = pend_epc_q;
    flush_cnt_d = flush_cnt_q;
    stall       = base_stall;
    flush       = 1'b0;
    new_pc      = 32'h0;
    case (state_q)
      RUN: begin
        if (bus.exc_type_i != 32'h0) begin
          if (!bus.stallreq_mem_i) begin
            flush       = 1'b1;
            stall       = 6'b000000;
            new_pc      = (bus.exc_type_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
            state_d     = DRAIN;
            flush_cnt_d = flush_cnt_q + 16'd1;
          end else begin
            pend_type_d = bus.exc_type_i;
            pend_epc_d  = bus.cp0_epc_i;
            state_d     = DEFER;
          end
        end
      end
      DEFER: begin
        if (!bus.stallreq_mem_i) begin
          flush       = 1'b1;
          stall       = 6'b000000;
          new_pc      = (pend_type_q == ERET_CODE) ? pend_epc_q : EXC_VECTOR;
          state_d     = DRAIN;
          flush_cnt_d = flush_cnt_q + 16'd1;
        end
      end
      DRAIN: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (rst) begin
      stall  = 6'b000000;
      flush  = 1'b0;
      new_pc = 32'h0;
    end
  end

  // State and pending-exception registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pend_type_q <= 32'h0;
      pend_epc_q  <= 32'h0;
      flush_cnt_q <= 16'h0;
    end else begin
      state_q     <= state_d;
      pend_type_q <= pend_type_d;
      pend_epc_q  <= pend_epc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.flush_o     = flush;
  assign bus.new_pc_o    = new_pc;
  assign bus.flush_cnt_o = flush_cnt_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios then random traffic, with a
// reference model pushing expected outputs into a queue each cycle.
module tb_pipe_ctrl;

  localparam logic [31:0] VEC  = 32'hBFC00380;
  localparam logic [31:0] ERET = 32'h0000000E;

  logic       clk;
  logic       rst;
  logic [1:0] state_o;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int errors;

  // expected {state, cnt, new_pc, flush, stall}
  logic [56:0] exp_q[$];

  // reference model state (0 RUN, 1 DEFER, 2 DRAIN)
  logic [1:0]  m_state;
  logic [31:0] m_ptype;
  logic [31:0] m_pepc;
  logic [15:0] m_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, predict, compare before the edge, advance model.
  task automatic cycle(input logic r, input logic id, input logic exe, input logic mem,
                       input logic [31:0] exc, input logic [31:0] epc);
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic [1:0]  n_state;
    logic [31:0] n_ptype, n_pepc;
    logic [15:0] n_cnt;
    logic [56:0] item;
    logic        take;
    logic [31:0] tgt_type, tgt_epc;

    rst = r;
    bus.stallreq_id_i  = id;
    bus.stallreq_exe_i = exe;
    bus.stallreq_mem_i = mem;
    bus.exc_type_i     = exc;
    bus.cp0_epc_i      = epc;

    e_stall = mem ? 6'b011111 : (exe ? 6'b001111 : (id ? 6'b000111 : 6'b000000));
    e_flush = 1'b0;
    e_pc    = 32'h0;
    n_state = m_state;
    n_ptype = m_ptype;
    n_pepc  = m_pepc;
    n_cnt   = m_cnt;
    take    = 1'b0;
    tgt_type = 32'h0;
    tgt_epc  = 32'h0;

    if (m_state == 2'd0 && exc != 0 && !mem) begin
      take = 1'b1; tgt_type = exc; tgt_epc = epc;
    end else if (m_state == 2'd0 && exc != 0) begin
      n_ptype = exc; n_pepc = epc; n_state = 2'd1;
    end else if (m_state == 2'd1 && !mem) begin
      take = 1'b1; tgt_type = m_ptype; tgt_epc = m_pepc;
    end else if (m_state == 2'd2) begin
      n_state = 2'd0;
    end
    if (take) begin
      e_flush = 1'b1;
      e_stall = 6'b0;
      e_pc    = (tgt_type == ERET) ? tgt_epc : VEC;
      n_state = 2'd2;
      n_cnt   = m_cnt + 16'd1;
    end
    if (r) begin
      e_stall = 6'b0; e_flush = 1'b0; e_pc = 32'h0;
      n_state = 2'd0; n_ptype = 32'h0; n_pepc = 32'h0; n_cnt = 16'h0;
    end
    exp_q.push_back({m_state, m_cnt, e_pc, e_flush, e_stall});

    @(negedge clk);
    item = exp_q.pop_front();
    check_val("stall",     {26'h0, bus.stall_o},     {26'h0, item[5:0]});
    check_val("flush",     {31'h0, bus.flush_o},     {31'h0, item[6]});
    check_val("new_pc",    bus.new_pc_o,             item[38:7]);
    check_val("flush_cnt", {16'h0, bus.flush_cnt_o}, {16'h0, item[54:39]});
    check_val("state",     {30'h0, state_o},         {30'h0, item[56:55]});

    @(posedge clk);
    m_state = n_state;
    m_ptype = n_ptype;
    m_pepc  = n_pepc;
    m_cnt   = n_cnt;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_state = 2'd0; m_ptype = 32'h0; m_pepc = 32'h0; m_cnt = 16'h0;
    rst = 1'b1;
    bus.stallreq_id_i = 0; bus.stallreq_exe_i = 0; bus.stallreq_mem_i = 0;
    bus.exc_type_i = 0; bus.cp0_epc_i = 0;
    @(posedge clk); #1;

    // reset with busy inputs: outputs must stay quiet
    cycle(1, 1, 1, 1, 32'h8, 32'h55);
    cycle(1, 0, 0, 0, 32'h0, 32'h0);

    // idle
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 32'h0, 32'h0);
    check_val("idle_cnt", {16'h0, bus.flush_cnt_o}, 32'd0);

    // stall priority
    cycle(0, 1, 1, 0, 32'h0, 32'h0);
    cycle(0, 1, 1, 1, 32'h0, 32'h0);
    cycle(0, 1, 0, 0, 32'h0, 32'h0);

    // immediate exception over an EXE stall, then DRAIN ignores exc
    cycle(0, 0, 1, 0, 32'h8, 32'h0);
    cycle(0, 0, 1, 0, 32'h8, 32'h0);
    check_val("imm_cnt", {16'h0, bus.flush_cnt_o}, 32'd1);

    // ERET
    cycle(0, 0, 0, 0, ERET, 32'hBFC01234);
    cycle(0, 0, 0, 0, 32'h0, 32'h0);

    // deferred exception: 3 MEM-stall cycles, inputs change after the first
    cycle(0, 0, 0, 1, 32'h4, 32'h1);
    cycle(0, 0, 0, 1, 32'h20, 32'h5);
    cycle(0, 1, 0, 1, ERET, 32'h99);
    cycle(0, 0, 0, 0, 32'h0, 32'h0);
    cycle(0, 0, 0, 0, 32'h0, 32'h0);
    check_val("defer_cnt", {16'h0, bus.flush_cnt_o}, 32'd3);

    // deferred ERET uses latched EPC
    cycle(0, 0, 0, 1, ERET, 32'h12345678);
    cycle(0, 0, 0, 0, 32'h0, 32'h0);
    cycle(0, 0, 0, 0, 32'h0, 32'h0);

    // reset mid-DEFER discards the pending exception
    cycle(0, 0, 0, 1, 32'h4, 32'h0);
    cycle(1, 0, 0, 0, 32'h4, 32'h0);
    cycle(0, 0, 0, 0, 32'h0, 32'h0);
    cycle(0, 0, 0, 0, 32'h0, 32'h0);
    check_val("rst_defer_cnt", {16'h0, bus.flush_cnt_o}, 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] exc;
      exc = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? ERET : $urandom_range(1, 31)) : 32'h0;
      cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 2) == 0), exc, $urandom);
    end

    check_val("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
